// File: rtl/decode_queue_stage_pkg.sv
// rtl/decode_queue_stage_pkg.sv - instruction field helpers and output record for the decode queue
package decode_queue_stage_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] pc_j;
    logic [XLEN-1:0] pc_b;
    logic            exc;
    logic [4:0]      exccode;
  } dec_out_t;

  function automatic logic [RW-1:0] get_rs(input logic [XLEN-1:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [RW-1:0] get_rt(input logic [XLEN-1:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [15:0] get_imm(input logic [XLEN-1:0] inst);
    return inst[15:0];
  endfunction

  function automatic logic [25:0] get_index(input logic [XLEN-1:0] inst);
    return inst[25:0];
  endfunction

  // Targets are relative to the delay-slot PC, not the branch itself.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] inst);
    logic [XLEN-1:0] seq_pc;
    seq_pc = pc + 32'd4;
    return {seq_pc[31:28], get_index(inst), 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] inst);
    logic [XLEN-1:0] seq_pc;
    logic [15:0]     imm;
    seq_pc = pc + 32'd4;
    imm    = get_imm(inst);
    return seq_pc + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/decode_queue_stage_if.sv
// rtl/decode_queue_stage_if.sv - fetch-to-decode stream carrying pc, instruction and exception
interface decode_queue_stage_if;

  logic        tvalid;
  logic        tready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        exc;
  logic [4:0]  exccode;

  modport master (
    output tvalid,
    output pc,
    output inst,
    output exc,
    output exccode,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  pc,
    input  inst,
    input  exc,
    input  exccode,
    output tready
  );

endinterface

// File: rtl/decode_queue_stage_fwd_select.sv
// rtl/decode_queue_stage_fwd_select.sv - priority forwarding mux for one operand
module fwd_select
  import decode_queue_stage_pkg::*;
#(
  parameter int N_FWD = 3
) (
  input  logic [RW-1:0]         raddr_i,
  input  logic [XLEN-1:0]       rf_rdata_i,
  input  logic [RW*N_FWD-1:0]   fwd_addr_i,
  input  logic [XLEN*N_FWD-1:0] fwd_data_i,
  input  logic [N_FWD-1:0]      fwd_ok_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  stall_o
);

  logic hit;

  // Source 0 is the youngest producer; once it matches, older sources are ignored
  // even if they already hold a value.
  always_comb begin
    data_o  = rf_rdata_i;
    stall_o = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < N_FWD; k++) begin
      if (!hit && (raddr_i != '0) && (fwd_addr_i[RW*k +: RW] == raddr_i)) begin
        hit     = 1'b1;
        data_o  = fwd_data_i[XLEN*k +: XLEN];
        stall_o = !fwd_ok_i[k];
      end
    end
  end

endmodule

// File: rtl/decode_queue_stage.sv
// rtl/decode_queue_stage.sv - instruction queue between fetch and issue with operand forwarding
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int N_FWD = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  decode_queue_stage_if.slave      fetch,
  input  logic                     flush_i,
  output logic [RW-1:0]            rf_raddr1_o,
  output logic [RW-1:0]            rf_raddr2_o,
  input  logic [XLEN-1:0]          rf_rdata1_i,
  input  logic [XLEN-1:0]          rf_rdata2_i,
  input  logic [RW*N_FWD-1:0]      fwd_addr_i,
  input  logic [XLEN*N_FWD-1:0]    fwd_data_i,
  input  logic [N_FWD-1:0]         fwd_ok_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          inst_o,
  output logic [XLEN-1:0]          rdata1_o,
  output logic [XLEN-1:0]          rdata2_o,
  output logic [XLEN-1:0]          pc_j_o,
  output logic [XLEN-1:0]          pc_b_o,
  output logic                     exc_o,
  output logic [4:0]               exccode_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              perfcnt_fwd_stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem      [DEPTH];
  logic [XLEN-1:0] inst_mem    [DEPTH];
  logic            exc_mem     [DEPTH];
  logic [4:0]      exccode_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  dec_out_t      out_q, out_d;
  logic [31:0]   perf_q, perf_d;

  logic            empty, full, push, pop, stall, stall1, stall2;
  logic [XLEN-1:0] head_pc, head_inst, opnd1, opnd2;
  logic            head_exc;
  logic [4:0]      head_exccode;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Ready is a function of occupancy only, so a full queue frees a slot one cycle after a pop.
  assign fetch.tready = !full;

  assign head_pc      = pc_mem[rd_ptr_q];
  assign head_inst    = inst_mem[rd_ptr_q];
  assign head_exc     = exc_mem[rd_ptr_q];
  assign head_exccode = exccode_mem[rd_ptr_q];

  assign rf_raddr1_o = get_rs(head_inst);
  assign rf_raddr2_o = get_rt(head_inst);

  fwd_select #(.N_FWD(N_FWD)) u_fwd1 (
    .raddr_i    (rf_raddr1_o),
    .rf_rdata_i (rf_rdata1_i),
    .fwd_addr_i (fwd_addr_i),
    .fwd_data_i (fwd_data_i),
    .fwd_ok_i   (fwd_ok_i),
    .data_o     (opnd1),
    .stall_o    (stall1)
  );

  fwd_select #(.N_FWD(N_FWD)) u_fwd2 (
    .raddr_i    (rf_raddr2_o),
    .rf_rdata_i (rf_rdata2_i),
    .fwd_addr_i (fwd_addr_i),
    .fwd_data_i (fwd_data_i),
    .fwd_ok_i   (fwd_ok_i),
    .data_o     (opnd2),
    .stall_o    (stall2)
  );

  // An excepting entry never executes, so its operands are irrelevant and it must not wait.
  assign stall = !head_exc && (stall1 || stall2);
  assign push  = fetch.tvalid && !full && !flush_i;
  assign pop   = !empty && !stall && (!valid_q || ready_i) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (pop) begin
      valid_d       = 1'b1;
      out_d.pc      = head_pc;
      out_d.inst    = head_inst;
      out_d.rdata1  = opnd1;
      out_d.rdata2  = opnd2;
      out_d.pc_j    = jump_target(head_pc, head_inst);
      out_d.pc_b    = branch_target(head_pc, head_inst);
      out_d.exc     = head_exc;
      out_d.exccode = head_exccode;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign perf_d = perf_q + 32'(!empty && stall && !flush_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      perf_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      perf_q   <= perf_d;
    end
  end

  // Storage carries no reset; occupancy alone says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]      <= fetch.pc;
      inst_mem[wr_ptr_q]    <= fetch.inst;
      exc_mem[wr_ptr_q]     <= fetch.exc;
      exccode_mem[wr_ptr_q] <= fetch.exccode;
    end
  end

  assign valid_o             = valid_q;
  assign pc_o                = out_q.pc;
  assign inst_o              = out_q.inst;
  assign rdata1_o            = out_q.rdata1;
  assign rdata2_o            = out_q.rdata2;
  assign pc_j_o              = out_q.pc_j;
  assign pc_b_o              = out_q.pc_b;
  assign exc_o               = out_q.exc;
  assign exccode_o           = out_q.exccode;
  assign count_o             = count_q;
  assign perfcnt_fwd_stall_o = perf_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// tb/tb_decode_queue_stage.sv - scoreboard bench for decode_queue_stage
module tb_decode_queue_stage;

  localparam int DEPTH = 4;
  localparam int N_FWD = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  code;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  flush;
  logic [4:0]            raddr1, raddr2;
  logic [31:0]           rf_rd1, rf_rd2;
  logic [5*N_FWD-1:0]    fwd_addr;
  logic [32*N_FWD-1:0]   fwd_data;
  logic [N_FWD-1:0]      fwd_ok;
  logic                  ready;
  logic                  valid_o;
  logic [31:0]           pc_o, inst_o, rdata1_o, rdata2_o, pc_j_o, pc_b_o;
  logic                  exc_o;
  logic [4:0]            exccode_o;
  logic [2:0]            count_o;
  logic [31:0]           perf_o;
  logic [31:0]           regs [32];

  decode_queue_stage_if fetch_if ();

  decode_queue_stage #(.DEPTH(DEPTH), .N_FWD(N_FWD)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch               (fetch_if),
    .flush_i             (flush),
    .rf_raddr1_o         (raddr1),
    .rf_raddr2_o         (raddr2),
    .rf_rdata1_i         (rf_rd1),
    .rf_rdata2_i         (rf_rd2),
    .fwd_addr_i          (fwd_addr),
    .fwd_data_i          (fwd_data),
    .fwd_ok_i            (fwd_ok),
    .ready_i             (ready),
    .valid_o             (valid_o),
    .pc_o                (pc_o),
    .inst_o              (inst_o),
    .rdata1_o            (rdata1_o),
    .rdata2_o            (rdata2_o),
    .pc_j_o              (pc_j_o),
    .pc_b_o              (pc_b_o),
    .exc_o               (exc_o),
    .exccode_o           (exccode_o),
    .count_o             (count_o),
    .perfcnt_fwd_stall_o (perf_o)
  );

  assign rf_rd1 = regs[raddr1];
  assign rf_rd2 = regs[raddr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Operand value as the issue stage should see it: youngest matching producer, else regfile.
  function automatic logic [32:0] resolve(input logic [4:0] a);
    if (a == 5'd0) return {1'b0, regs[0]};
    for (int k = 0; k < N_FWD; k++)
      if (fwd_addr[5*k +: 5] == a) return {!fwd_ok[k], fwd_data[32*k +: 32]};
    return {1'b0, regs[a]};
  endfunction

  function automatic logic [31:0] exp_pcj(input ent_t e);
    logic [31:0] seq;
    seq = e.pc + 32'd4;
    return (seq & 32'hF000_0000) | ({6'd0, e.inst[25:0]} * 32'd4);
  endfunction

  function automatic logic [31:0] exp_pcb(input ent_t e);
    logic signed [31:0] off;
    off = $signed(e.inst[15:0]);
    return e.pc + 32'd4 + 32'(off * 4);
  endfunction

  // Scoreboard state
  ent_t        exp_q [$];
  ent_t        m_ent, s_ent, h;
  logic [31:0] m_r1, m_r2, s_r1, s_r2;
  logic        m_valid = 1'b0;
  logic [31:0] perf_m  = 32'd0;
  logic        snap_ok = 1'b0;
  logic        s_reset, s_flush, s_ready, s_push, s_pop, s_stall, st1, st2;

  always @(negedge clk) begin
    if (snap_ok) begin
      if (s_reset) begin
        exp_q.delete();
        m_valid = 1'b0;
        perf_m  = 32'd0;
      end else if (s_flush) begin
        exp_q.delete();
        m_valid = 1'b0;
      end else begin
        if (s_stall) perf_m++;
        if (s_pop) begin
          m_ent   = exp_q.pop_front();
          m_r1    = s_r1;
          m_r2    = s_r2;
          m_valid = 1'b1;
        end else if (s_ready) begin
          m_valid = 1'b0;
        end
        if (s_push) exp_q.push_back(s_ent);
      end
      check("valid_o", 32'(valid_o), 32'(m_valid));
      check("count_o", 32'(count_o), 32'(exp_q.size()));
      check("fetch_ready", 32'(fetch_if.tready), 32'(exp_q.size() != DEPTH));
      check("perfcnt", perf_o, perf_m);
      if (s_reset) begin
        check("rst_pc_o", pc_o, 32'd0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_rdata", rdata1_o | rdata2_o, 32'd0);
        check("rst_targets", pc_j_o | pc_b_o, 32'd0);
        check("rst_exc", {26'd0, exc_o, exccode_o}, 32'd0);
      end
      if (m_valid) begin
        check("pc_o", pc_o, m_ent.pc);
        check("inst_o", inst_o, m_ent.inst);
        check("pc_j_o", pc_j_o, exp_pcj(m_ent));
        check("pc_b_o", pc_b_o, exp_pcb(m_ent));
        check("exc_o", 32'(exc_o), 32'(m_ent.exc));
        check("exccode_o", 32'(exccode_o), 32'(m_ent.code));
        if (!m_ent.exc) begin
          check("rdata1_o", rdata1_o, m_r1);
          check("rdata2_o", rdata2_o, m_r2);
        end
      end
    end
    snap_ok = 1'b1;
    s_reset = reset;
    s_flush = flush;
    s_ready = ready;
    s_push  = fetch_if.tvalid && (exp_q.size() != DEPTH);
    s_ent   = '{pc: fetch_if.pc, inst: fetch_if.inst, exc: fetch_if.exc, code: fetch_if.exccode};
    s_stall = 1'b0;
    s_pop   = 1'b0;
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      {st1, s_r1} = resolve(h.inst[25:21]);
      {st2, s_r2} = resolve(h.inst[20:16]);
      s_stall = !h.exc && (st1 || st2);
      s_pop   = !s_stall && (!m_valid || ready);
    end
  end

  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd6;
      3:       return 5'd7;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic offer(input logic [4:0] rs, input logic [4:0] rt, input logic exc,
                       input logic [4:0] code);
    logic [31:0] r;
    r = $urandom;
    fetch_if.tvalid  = 1'b1;
    fetch_if.pc      = pc_ctr;
    fetch_if.inst    = {r[31:26], rs, rt, r[15:0]};
    fetch_if.exc     = exc;
    fetch_if.exccode = code;
    pc_ctr           = pc_ctr + 32'd4;
  endtask

  task automatic set_fwd(input int k, input logic [4:0] a, input logic ok);
    fwd_addr[5*k +: 5]  = a;
    fwd_ok[k]           = ok;
    fwd_data[32*k +: 32] = $urandom;
  endtask

  task automatic clear_fwd();
    for (int k = 0; k < N_FWD; k++) set_fwd(k, 5'd0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    reset = 1'b1;
    flush = 1'b0;
    ready = 1'b1;
    fetch_if.tvalid = 1'b0;
    fetch_if.pc = '0;
    fetch_if.inst = '0;
    fetch_if.exc = 1'b0;
    fetch_if.exccode = '0;
    clear_fwd();
    tick(3);
    reset = 1'b0;

    // Hazard-free stream
    for (int i = 0; i < 6; i++) begin
      offer(5'($urandom), 5'($urandom), 1'b0, 5'($urandom));
      tick();
    end
    fetch_if.tvalid = 1'b0;
    tick(4);

    // Downstream backpressure while fetch keeps offering
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      offer(5'($urandom), 5'($urandom), 1'b0, 5'd0);
      tick();
    end
    fetch_if.tvalid = 1'b0;
    ready = 1'b1;
    tick(8);

    // Youngest source pending on rs=5 blocks despite an older ready source; exception behind it
    set_fwd(0, 5'd5, 1'b0);
    set_fwd(1, 5'd5, 1'b1);
    offer(5'd5, 5'd1, 1'b0, 5'd0);
    tick();
    offer(5'd5, 5'd2, 1'b1, 5'h04);
    tick();
    fetch_if.tvalid = 1'b0;
    tick(4);
    fwd_ok[0] = 1'b1;
    tick();
    fwd_ok[0] = 1'b0;
    tick(4);
    clear_fwd();
    tick(3);

    // rt=0 never matches a source that names register 0
    set_fwd(0, 5'd0, 1'b0);
    offer(5'd3, 5'd0, 1'b0, 5'd0);
    tick();
    fetch_if.tvalid = 1'b0;
    tick(4);
    clear_fwd();

    // Flush with a full queue, a held output and a concurrent fetch offer
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(5'($urandom), 5'($urandom), 1'b0, 5'd0);
      tick();
    end
    flush = 1'b1;
    offer(5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    flush = 1'b0;
    fetch_if.tvalid = 1'b0;
    ready = 1'b1;
    tick(3);

    // Randomized traffic with hazards, flushes and one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 7)
        offer(pick_reg(), pick_reg(), ($urandom_range(0, 9) == 0), 5'($urandom));
      else
        fetch_if.tvalid = 1'b0;
      ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      reset = (c == 1500);
      for (int k = 0; k < N_FWD; k++) set_fwd(k, pick_reg(), ($urandom_range(0, 9) < 6));
      tick();
    end

    fetch_if.tvalid = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
    ready = 1'b1;
    clear_fwd();
    tick(12);
    check("drain_count", 32'(count_o), 32'd0);
    check("drain_valid", 32'(valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
